// File: rtl/rf_exec_sequencer.sv
// Multi-cycle execute/control stage for the 8x8 register file: accepts one
// instruction per handshake and sequences register read -> ALU -> writeback.
module rf_exec_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [3+3*ADDR_W+IMM_W-1:0]   instr,
  output logic [ADDR_W-1:0]             rf_read_port_1,
  output logic [ADDR_W-1:0]             rf_read_port_2,
  input  logic [DATA_W-1:0]             rf_read_data_1,
  input  logic [DATA_W-1:0]             rf_read_data_2,
  output logic [ADDR_W-1:0]             rf_write_port,
  output logic [DATA_W-1:0]             rf_write_data,
  output logic                          rf_write_enable,
  output logic                          busy,
  output logic                          done,
  output logic                          zero_flag,
  output logic                          carry_flag
);

  localparam int INSTR_W = 3 + 3*ADDR_W + IMM_W;
  localparam int SUM_W   = DATA_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_e;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ADDI = 3'd5,
    OP_SHL  = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  state_e            state;
  op_e               op_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] result_q;

  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [IMM_W-1:0]  instr_imm;

  assign instr_op  = instr[INSTR_W-1 -: 3];
  assign instr_rd  = instr[IMM_W+3*ADDR_W-1 -: ADDR_W];
  assign instr_rs1 = instr[IMM_W+2*ADDR_W-1 -: ADDR_W];
  assign instr_rs2 = instr[IMM_W+ADDR_W-1 -: ADDR_W];
  assign instr_imm = instr[IMM_W-1:0];

  assign rf_write_data = result_q;

  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // Arithmetic is done one bit wider so the top bit is carry (ADD) or borrow (SUB).
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum       = SUM_W'(rf_read_data_1) + SUM_W'(rf_read_data_2);
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_SUB: begin
        sum       = SUM_W'(rf_read_data_1) - SUM_W'(rf_read_data_2);
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_AND: alu_res = rf_read_data_1 & rf_read_data_2;
      OP_OR:  alu_res = rf_read_data_1 | rf_read_data_2;
      OP_XOR: alu_res = rf_read_data_1 ^ rf_read_data_2;
      OP_ADDI: begin
        sum       = SUM_W'(rf_read_data_1) + SUM_W'(imm_q);
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_SHL: alu_res = rf_read_data_1 << rf_read_data_2[2:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      op_q            <= OP_ADD;
      imm_q           <= '0;
      result_q        <= '0;
      rf_read_port_1  <= '0;
      rf_read_port_2  <= '0;
      rf_write_port   <= '0;
      rf_write_enable <= 1'b0;
      instr_ready     <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      zero_flag       <= 1'b0;
      carry_flag      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q           <= op_e'(instr_op);
            imm_q          <= instr_imm;
            rf_read_port_1 <= instr_rs1;
            rf_read_port_2 <= instr_rs2;
            rf_write_port  <= instr_rd;
            instr_ready    <= 1'b0;
            busy           <= 1'b1;
            state          <= S_READ;
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          if (op_q == OP_NOP) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            result_q        <= alu_res;
            zero_flag       <= (alu_res == '0);
            carry_flag      <= alu_carry;
            rf_write_enable <= 1'b1;
            state           <= S_WRITE;
          end
        end
        S_WRITE: begin
          rf_write_enable <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b1;
          instr_ready     <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Directed bench for rf_exec_sequencer with a behavioural registered-read
// regfile model that the bench preloads through a side write port.
module tb_rf_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  rf_read_port_1, rf_read_port_2, rf_write_port;
  logic [7:0]  rf_read_data_1, rf_read_data_2, rf_write_data;
  logic        rf_write_enable, busy, done, zero_flag, carry_flag;

  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem [8];
  int          wr_count = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_exec_sequencer #(.DATA_W(8), .ADDR_W(3), .IMM_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_read_port_1(rf_read_port_1), .rf_read_port_2(rf_read_port_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rf_write_port(rf_write_port), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .busy(busy), .done(done), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  always @(posedge clk) begin
    rf_read_data_1 <= mem[rf_read_port_1];
    rf_read_data_2 <= mem[rf_read_port_2];
    if (rf_write_enable) mem[rf_write_port] <= rf_write_data;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  always @(posedge clk) if (rf_write_enable) wr_count <= wr_count + 1;

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one ALU instruction and checks every cycle from accept to done.
  task automatic run_alu(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [3:0] imm, input logic [7:0] exp,
                         input logic exp_z, input logic exp_c, input string name);
    int wc0;
    @(negedge clk);
    instr = {op, rd, rs1, rs2, imm}; instr_valid = 1'b1;
    wc0 = wr_count;
    @(negedge clk);  // cycle k: READ
    instr_valid = 1'b0;
    tests++;
    if ({busy, instr_ready, rf_write_enable, done, rf_read_port_1, rf_read_port_2, rf_write_port}
        !== {4'b1000, rs1, rs2, rd}) begin
      fails++;
      $display("FAIL %s_read: got b/r/we/d/p1/p2/wp=%b%b%b%b/%0d/%0d/%0d want 1000/%0d/%0d/%0d",
               name, busy, instr_ready, rf_write_enable, done, rf_read_port_1, rf_read_port_2,
               rf_write_port, rs1, rs2, rd);
    end
    @(negedge clk);  // k+1: EXEC
    tests++;
    if ({rf_write_enable, done} !== 2'b00) begin
      fails++;
      $display("FAIL %s_exec: got we/done=%b%b want 00", name, rf_write_enable, done);
    end
    @(negedge clk);  // k+2: WRITE
    tests++;
    if ({rf_write_enable, done, rf_write_data} !== {2'b10, exp}) begin
      fails++;
      $display("FAIL %s_write: got we/done=%b%b data=%h want 10 data=%h",
               name, rf_write_enable, done, rf_write_data, exp);
    end
    @(negedge clk);  // k+3: done
    tests++;
    if ({done, rf_write_enable, instr_ready, busy, zero_flag, carry_flag, mem[rd]}
        !== {4'b1010, exp_z, exp_c, exp}) begin
      fails++;
      $display("FAIL %s_done: got d/we/r/b=%b%b%b%b z=%b c=%b r%0d=%h want 1010 z=%b c=%b r=%h",
               name, done, rf_write_enable, instr_ready, busy, zero_flag, carry_flag, rd, mem[rd],
               exp_z, exp_c, exp);
    end
    tests++;
    if (wr_count - wc0 !== 1) begin
      fails++;
      $display("FAIL %s_wrcount: got %0d writes want 1", name, wr_count - wc0);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({instr_ready, busy, done, rf_write_enable, zero_flag, carry_flag} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_hold: got r/b/d/we/z/c=%b%b%b%b%b%b want 100000",
               instr_ready, busy, done, rf_write_enable, zero_flag, carry_flag);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({instr_ready, busy, done, rf_write_enable, rf_read_port_1, rf_read_port_2,
         rf_write_port, rf_write_data} !== {4'b1000, 9'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_release: got r/b/d/we=%b%b%b%b ports=%0d/%0d/%0d data=%h want 1000 0/0/0 00",
               instr_ready, busy, done, rf_write_enable, rf_read_port_1, rf_read_port_2,
               rf_write_port, rf_write_data);
    end
  endtask

  task automatic test_add;
    preload(3'd1, 8'h0F);
    preload(3'd2, 8'h01);
    run_alu(3'b000, 3'd3, 3'd1, 3'd2, 4'h0, 8'h10, 1'b0, 1'b0, "add");
  endtask

  task automatic test_overflow_sub;
    preload(3'd1, 8'hFF);
    run_alu(3'b000, 3'd4, 3'd1, 3'd2, 4'h0, 8'h00, 1'b1, 1'b1, "add_wrap");
    run_alu(3'b001, 3'd5, 3'd2, 3'd1, 4'h0, 8'h02, 1'b0, 1'b1, "sub_borrow");
  endtask

  task automatic test_addi;
    preload(3'd1, 8'hF5);
    run_alu(3'b101, 3'd1, 3'd1, 3'd0, 4'hF, 8'h04, 1'b0, 1'b1, "addi_rd_eq_rs1");
  endtask

  task automatic test_mid_reset;
    int wc0;
    preload(3'd7, 8'hAA);
    @(negedge clk);
    instr = {3'b000, 3'd7, 3'd1, 3'd2, 4'h0}; instr_valid = 1'b1;
    wc0 = wr_count;
    @(negedge clk);  // READ
    instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    tests++;
    if ({busy, carry_flag} !== 2'b11) begin
      fails++;
      $display("FAIL midrst_pre: got busy/carry=%b%b want 11", busy, carry_flag);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({instr_ready, busy, done, rf_write_enable, zero_flag, carry_flag} !== 6'b100000) begin
      fails++;
      $display("FAIL midrst_async: got r/b/d/we/z/c=%b%b%b%b%b%b want 100000",
               instr_ready, busy, done, rf_write_enable, zero_flag, carry_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({rf_write_enable, instr_ready, busy, done} !== 4'b0100) begin
        fails++;
        $display("FAIL midrst_idle: got we/r/b/d=%b%b%b%b want 0100",
                 rf_write_enable, instr_ready, busy, done);
      end
    end
    tests++;
    if ({wr_count - wc0, mem[7]} !== {32'd0, 8'hAA}) begin
      fails++;
      $display("FAIL midrst_nowrite: got writes=%0d r7=%h want 0 AA", wr_count - wc0, mem[7]);
    end
  endtask

  task automatic test_shl_nop;
    int wc0;
    preload(3'd1, 8'h81);
    preload(3'd2, 8'h03);
    run_alu(3'b110, 3'd6, 3'd1, 3'd2, 4'h0, 8'h08, 1'b0, 1'b0, "shl");
    run_alu(3'b011, 3'd7, 3'd1, 3'd2, 4'h0, 8'h83, 1'b0, 1'b0, "or");
    run_alu(3'b001, 3'd0, 3'd2, 3'd1, 4'h0, 8'h82, 1'b0, 1'b1, "sub_pre_nop");
    @(negedge clk);
    instr = {3'b111, 3'd5, 3'd1, 3'd2, 4'h0}; instr_valid = 1'b1;
    wc0 = wr_count;
    @(negedge clk);  // READ
    instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    tests++;
    if ({rf_write_enable, done, busy} !== 3'b001) begin
      fails++;
      $display("FAIL nop_exec: got we/done/busy=%b%b%b want 001", rf_write_enable, done, busy);
    end
    @(negedge clk);  // k+2: done
    tests++;
    if ({done, rf_write_enable, instr_ready, busy, zero_flag, carry_flag} !== 6'b101001) begin
      fails++;
      $display("FAIL nop_done: got d/we/r/b/z/c=%b%b%b%b%b%b want 101001",
               done, rf_write_enable, instr_ready, busy, zero_flag, carry_flag);
    end
    tests++;
    if ({wr_count - wc0, mem[5]} !== {32'd0, 8'h02}) begin
      fails++;
      $display("FAIL nop_nowrite: got writes=%0d r5=%h want 0 02", wr_count - wc0, mem[5]);
    end
  endtask

  // instr_valid stays high across three instructions; accepts only on ready cycles.
  task automatic test_back_to_back;
    logic [15:0] prog [3];
    int acc, idx, n_done, n_we, wc0;
    logic pend, exp_we, exp_done, exp_ready;
    prog[0] = {3'b000, 3'd3, 3'd1, 3'd2, 4'h0};  // r3 = 81+03 = 84
    prog[1] = {3'b100, 3'd4, 3'd3, 3'd1, 4'h0};  // r4 = 84^81 = 05
    prog[2] = {3'b010, 3'd5, 3'd4, 3'd2, 4'h0};  // r5 = 05&03 = 01
    acc = -10; idx = 0; n_done = 0; n_we = 0; pend = 1'b0;
    wc0 = wr_count;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (pend) begin acc = c; idx++; pend = 1'b0; end
      exp_we    = (c == acc + 2);
      exp_done  = (c == acc + 3);
      exp_ready = (c >= acc + 3);
      if (done) n_done++;
      if (rf_write_enable) n_we++;
      tests++;
      if ({rf_write_enable, done, instr_ready} !== {exp_we, exp_done, exp_ready}) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got we/done/ready=%b%b%b want %b%b%b",
                 c, rf_write_enable, done, instr_ready, exp_we, exp_done, exp_ready);
      end
      if (idx < 3) begin
        instr = prog[idx]; instr_valid = 1'b1; pend = instr_ready;
      end else begin
        instr_valid = 1'b0;
      end
    end
    tests++;
    if ({idx, n_done, n_we, wr_count - wc0} !== {32'd3, 32'd3, 32'd3, 32'd3}) begin
      fails++;
      $display("FAIL b2b_counts: got accepts=%0d dones=%0d we=%0d writes=%0d want 3 3 3 3",
               idx, n_done, n_we, wr_count - wc0);
    end
    tests++;
    if ({mem[3], mem[4], mem[5]} !== {8'h84, 8'h05, 8'h01}) begin
      fails++;
      $display("FAIL b2b_results: got r3=%h r4=%h r5=%h want 84 05 01", mem[3], mem[4], mem[5]);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_overflow_sub;
    test_addi;
    test_mid_reset;
    test_shl_nop;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
